// File: rtl/multicore_pkg.sv
// Shared types for the multicore top level: store sizes, arbiter FSM states
// and the byte-lane helper used by the data-memory arbiter.
package multicore_pkg;

   localparam int unsigned NUM_CORES_DEF = 4;

   typedef enum logic [1:0] {
      SOP_SB = 2'd0,
      SOP_SH = 2'd1,
      SOP_SW = 2'd2
   } t_sop;

   localparam int unsigned SOP_W = $bits(t_sop);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACK
   } t_arb_state;

   typedef struct packed {
      logic [3:0] be;
      logic       misalign;
   } t_lane;

   // A misaligned store keeps its memory slot but writes no bytes.
   function automatic t_lane store_lanes(input t_sop sop, input logic [1:0] a);
      t_lane l;
      l = '0;
      case (sop)
         SOP_SB: l.be = 4'b0001 << a;
         SOP_SH: begin
            l.misalign = a[0];
            l.be       = a[0] ? 4'b0000 : (4'b0011 << a);
         end
         default: begin
            l.misalign = (a != 2'd0);
            l.be       = (a != 2'd0) ? 4'b0000 : 4'b1111;
         end
      endcase
      return l;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Round-robin winner selection: rotate the request vector so the pointer
// position is bit 0, then take the lowest set bit.
module rr_picker #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned IDX_W     = $clog2(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic                 valid,
   output logic [IDX_W-1:0]     idx
);

   logic [NUM_CORES-1:0] rot;
   logic                 found;

   function automatic int unsigned wrap(input int unsigned v);
      return (v >= NUM_CORES) ? v - NUM_CORES : v;
   endfunction

   always_comb begin
      rot   = '0;
      valid = |req;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         rot[i] = req[wrap(int'(ptr) + i)];
      end
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            idx   = IDX_W'(wrap(int'(ptr) + i));
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the
// memory stages of NUM_CORES pipelines; one transaction in flight at a time.
module dmem_arbiter
   import multicore_pkg::*;
#(
   parameter int unsigned NUM_CORES = NUM_CORES_DEF,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_LAT   = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [NUM_CORES-1:0]        i_req,
   input  logic [NUM_CORES-1:0]        i_we,
   input  logic [NUM_CORES*ADDR_W-1:0] i_addr,
   input  logic [NUM_CORES*DATA_W-1:0] i_wdata,
   input  logic [NUM_CORES*SOP_W-1:0]  i_sop,
   output logic [NUM_CORES-1:0]        o_ack,
   output logic [NUM_CORES-1:0]        o_stall,
   output logic [DATA_W-1:0]           o_rdata,
   output logic                        o_misalign,
   output logic                        o_mem_en,
   output logic                        o_mem_we,
   output logic [ADDR_W-1:0]           o_mem_addr,
   output logic [DATA_W-1:0]           o_mem_wdata,
   output logic [3:0]                  o_mem_be,
   input  logic [DATA_W-1:0]           i_mem_rdata
);

   localparam int unsigned IDX_W = $clog2(NUM_CORES);
   localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

   t_arb_state        state, state_nx;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  win_idx;
   logic              win_mis;
   logic [LAT_W-1:0]  lat_cnt;

   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   t_sop              sel_sop;
   t_lane             sel_lane;

   rr_picker #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_picker (
      .req   (i_req),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      sel_we    = i_we[pick_idx];
      sel_addr  = i_addr[pick_idx*ADDR_W +: ADDR_W];
      sel_wdata = i_wdata[pick_idx*DATA_W +: DATA_W];
      sel_sop   = t_sop'(i_sop[pick_idx*SOP_W +: SOP_W]);
      sel_lane  = store_lanes(sel_sop, sel_addr[1:0]);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pick_valid) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (lat_cnt == '0) state_nx = ACK;
         ACK:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      o_ack = '0;
      if (state == ACK) o_ack[win_idx] = 1'b1;
      o_misalign = (state == ACK) && win_mis;
      o_stall    = i_req & ~o_ack;
   end

   // Memory port is loaded on the grant edge so it is valid exactly in ISSUE;
   // the latched request lives in these registers from then on.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         lat_cnt     <= '0;
         win_idx     <= '0;
         win_mis     <= 1'b0;
         o_rdata     <= '0;
         o_mem_en    <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_be    <= '0;
      end else begin
         state       <= state_nx;
         o_mem_en    <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_be    <= '0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  win_idx     <= pick_idx;
                  win_mis     <= sel_lane.misalign;
                  o_mem_en    <= 1'b1;
                  o_mem_we    <= sel_we;
                  o_mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
                  o_mem_wdata <= sel_wdata << {sel_addr[1:0], 3'b000};
                  o_mem_be    <= sel_we ? sel_lane.be : 4'b1111;
               end
            end
            ISSUE: lat_cnt <= LAT_W'(MEM_LAT - 1);
            WAIT: begin
               if (lat_cnt == '0) o_rdata <= i_mem_rdata;
               else               lat_cnt <= lat_cnt - 1'b1;
            end
            ACK: rr_ptr <= (win_idx == IDX_W'(NUM_CORES - 1)) ? '0 : win_idx + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases then randomized core
// traffic with resets, checked against a transaction-level arbiter model.
module tb_dmem_arbiter;
   import multicore_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned L  = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req, we;
   logic [N*AW-1:0] addr;
   logic [N*32-1:0] wdata;
   logic [N*2-1:0]  sop;
   logic [N-1:0]    ack, stall;
   logic [31:0]     rdata, mem_rdata, mem_addr, mem_wdata;
   logic            misalign, mem_en, mem_we;
   logic [3:0]      mem_be;

   dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(32), .MEM_LAT(L)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
      .i_wdata(wdata), .i_sop(sop), .o_ack(ack), .o_stall(stall),
      .o_rdata(rdata), .o_misalign(misalign), .o_mem_en(mem_en),
      .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .o_mem_be(mem_be), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // core-side request fields
   logic        c_we[N];
   logic [31:0] c_addr[N], c_wdata[N];
   int unsigned c_sop[N];
   bit          dir_v[N];
   logic        d_we[N];
   logic [31:0] d_addr[N], d_wdata[N];
   int unsigned d_sop[N];

   logic [31:0] env_mem[16], ref_mem[16];
   logic [31:0] pend;
   int          rd_cnt = 0;

   // reference model state
   bit          active = 0, rst_now = 1, force_rst = 0;
   bit          rand_en = 0, cont_en = 0, rec_en = 0;
   int          cyc = 0, t0 = 0, win = 0, ptr = 0;
   logic        cur_we, cur_mis;
   logic [31:0] cur_addr, cur_wd, exp_rd;
   logic [3:0]  cur_be;
   int          order_q[$];

   function automatic logic [4:0] exp_lanes(input logic w, input int unsigned s, input int unsigned a);
      int unsigned n;
      bit m;
      logic [3:0] b;
      n = (s == 0) ? 1 : (s == 1) ? 2 : 4;
      m = (a % n) != 0;
      b = w ? (m ? 4'h0 : 4'(((1 << n) - 1) << a)) : 4'hF;
      return {m, b};
   endfunction

   task automatic drive_bus();
      for (int k = 0; k < N; k++) begin
         we[k]              = c_we[k];
         addr[k*AW +: AW]   = c_addr[k];
         wdata[k*32 +: 32]  = c_wdata[k];
         sop[k*2 +: 2]      = 2'(c_sop[k]);
      end
   endtask

   task automatic raise_random(input int k);
      c_we[k] = 1'($urandom_range(0, 1)); c_sop[k] = $urandom_range(0, 2);
      c_addr[k] = $urandom; c_wdata[k] = $urandom; req[k] = 1'b1;
   endtask

   task automatic step();
      logic [N-1:0] exp_ack;
      logic [69:0]  exp_port;
      logic [4:0]   ln;
      int           acked;
      bit           new_rst;
      exp_ack = '0; exp_port = '0; acked = -1; new_rst = 0;
      cyc++;
      if (rst_now) begin
         check("rst_rdata", rdata, 0);
         check("rst_misalign", misalign, 0);
         rst_now = 0; rd_cnt = 0;
      end else if (active) begin
         int ph;
         ph = cyc - t0;
         if (ph == 1) begin
            exp_port = {1'b1, cur_we, cur_addr & ~32'h3, cur_wd, cur_be};
            if (cur_we)
               for (int b = 0; b < 4; b++)
                  if (cur_be[b]) ref_mem[cur_addr[5:2]][8*b +: 8] = cur_wd[8*b +: 8];
            exp_rd = ref_mem[cur_addr[5:2]];
         end
         if (ph == int'(L) + 2) begin
            exp_ack[win] = 1'b1;
            check("ack_misalign", misalign, cur_mis);
            if (!cur_we) check("load_rdata", rdata, exp_rd);
            active = 0; ptr = (win + 1) % N; acked = win;
            if (rec_en) order_q.push_back(win);
         end else check("misalign_idle", misalign, 0);
      end else check("misalign_idle", misalign, 0);
      check("mem_port", {mem_en, mem_we, mem_addr, mem_wdata, mem_be}, exp_port);
      check("ack", ack, exp_ack);
      check("stall", stall, req & ~exp_ack);

      // memory environment, returns read data L cycles after the enable
      mem_rdata = $urandom;
      if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) mem_rdata = pend;
      end
      if (mem_en) begin
         if (mem_we)
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) env_mem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
         pend = env_mem[mem_addr[5:2]]; rd_cnt = L;
      end

      // cores
      for (int k = 0; k < N; k++) begin
         if (acked == k) begin
            req[k] = 1'b0;
            if (cont_en) raise_random(k);
         end
         if (!req[k]) begin
            if (dir_v[k]) begin
               c_we[k] = d_we[k]; c_addr[k] = d_addr[k]; c_wdata[k] = d_wdata[k];
               c_sop[k] = d_sop[k]; req[k] = 1'b1; dir_v[k] = 0;
            end else if (rand_en && $urandom_range(0, 3) == 0) raise_random(k);
         end
      end
      if (active && rand_en && $urandom_range(0, 3) == 0) begin
         c_addr[win] = $urandom; c_wdata[win] = $urandom; c_sop[win] = $urandom_range(0, 2);
      end
      drive_bus();

      if (rst) rst = 1'b0;
      else if (force_rst || (rand_en && $urandom_range(0, 149) == 0)) begin
         rst = 1'b1; force_rst = 0; active = 0; ptr = 0; rst_now = 1; new_rst = 1;
      end

      if (!active && acked < 0 && !new_rst) begin
         for (int i = 0; i < N; i++) begin
            int idx;
            idx = (ptr + i) % N;
            if (req[idx]) begin
               win = idx; t0 = cyc; active = 1;
               cur_we = c_we[idx]; cur_addr = c_addr[idx];
               ln = exp_lanes(cur_we, c_sop[idx], int'(cur_addr[1:0]));
               cur_mis = ln[4]; cur_be = ln[3:0];
               cur_wd = 32'(c_wdata[idx] << (8 * cur_addr[1:0]));
               break;
            end
         end
      end
   endtask

   task automatic set_dir(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int unsigned s);
      d_we[k] = w; d_addr[k] = a; d_wdata[k] = d; d_sop[k] = s; dir_v[k] = 1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         step();
      end
   endtask

   initial begin
      rst = 1'b1; req = '0; mem_rdata = '0; pend = '0;
      for (int k = 0; k < N; k++) begin
         c_we[k] = 0; c_addr[k] = 0; c_wdata[k] = 0; c_sop[k] = 0; dir_v[k] = 0;
      end
      drive_bus();
      for (int i = 0; i < 16; i++) begin
         env_mem[i] = $urandom; ref_mem[i] = env_mem[i];
      end
      env_mem[1] = 32'hDEADBEEF; ref_mem[1] = 32'hDEADBEEF;

      set_dir(1, 1'b0, 32'h104, 32'h0, 2);            // word load
      run(10);
      set_dir(2, 1'b1, 32'h203, 32'h000000A5, 0);      // byte store, top lane
      run(10);
      set_dir(0, 1'b1, 32'h102, 32'h12345678, 2);      // misaligned SW
      set_dir(3, 1'b1, 32'h101, 32'h0000BEEF, 1);      // misaligned SH
      run(16);
      set_dir(2, 1'b0, 32'h203, 32'h0, 1);             // misaligned load
      run(10);

      force_rst = 1;
      run(1);
      cont_en = 1; rec_en = 1;
      for (int k = 0; k < N; k++) set_dir(k, 1'b0, 32'(k * 4), 32'h0, 2);
      run(1 + 5 * (L + 3));
      cont_en = 0; rec_en = 0;
      check("rr_count", order_q.size(), 5);
      for (int i = 0; i < order_q.size() && i < 5; i++) check("rr_order", order_q[i], i % N);

      rand_en = 1;
      run(4000);
      rand_en = 0;
      run(8 * (L + 3) * N);
      check("drained", req, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported data memory between the memory stages of NUM_CORES pipelines.
- Each core raises a load or store request and holds it until acknowledged. The arbiter grants one core at a time in round-robin order and drives the memory port.
- It returns raw read data and an ack, and drives per-core stall back to each pipeline.
- Sits between the per-core memory stages and the shared data RAM in the multicore top level.

Parameters:
NUM_CORES, 4, number of requesting cores (>=2, power of two not required)
ADDR_W, 32, byte address width
DATA_W, 32, data width (fixed 32; byte enables 4 bits)
MEM_LAT, 1, memory read latency in cycles after enable (>=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req  in  NUM_CORES  per-core request; held until matching o_ack
i_we  in  NUM_CORES  per-core 1=store, 0=load
i_addr  in  NUM_CORES*ADDR_W  per-core byte address, core k at [k*ADDR_W +: ADDR_W]
i_wdata  in  NUM_CORES*32  per-core store data, LSB-aligned
i_sop  in  NUM_CORES*$bits(t_sop)  per-core store size (SB/SH/SW)
o_ack  out  NUM_CORES  one-hot, one-cycle pulse: transaction of core k complete
o_stall  out  NUM_CORES  i_req[k] & ~o_ack[k]
o_rdata  out  32  raw aligned word read; valid when any o_ack set
o_misalign  out  1  pulses with o_ack when the acked access was misaligned
o_mem_en  out  1  memory enable, one cycle per transaction
o_mem_we  out  1  memory write
o_mem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 0)
o_mem_wdata  out  32  store data shifted to byte lane
o_mem_be  out  4  byte enables
i_mem_rdata  in  32  read data, valid MEM_LAT cycles after o_mem_en

Behaviour:
- Reset (synchronous, i_rst high at the clock edge):
  - state=IDLE, rr_ptr=0, lat_cnt=0.
  - All outputs 0: o_ack, o_rdata, o_misalign, o_mem_*.
  - An in-flight transaction is dropped with no ack. A write already issued to memory is not undone.
- FSM states IDLE, ISSUE, WAIT, ACK:
  - IDLE: if any i_req, pick the first requester at or after rr_ptr (ascending, wrapping). Latch winner index, we, addr, wdata, sop. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: registered o_mem_* outputs are valid for exactly this cycle. lat_cnt=MEM_LAT-1. Go to WAIT.
  - WAIT: decrement lat_cnt. When lat_cnt==0, capture i_mem_rdata into o_rdata and go to ACK.
  - ACK: o_ack[winner]=1 and o_misalign as computed; rr_ptr=(winner+1) mod NUM_CORES. Go to IDLE.
- Latency: request seen in IDLE at cycle 0 -> ack at cycle MEM_LAT+2. One transaction every MEM_LAT+3 cycles.
- Requests are latched at grant. Deasserting or changing i_req/i_addr after grant has no effect on the in-flight transaction. Losing requesters stay stalled.
- Stores also traverse WAIT; o_rdata is don't-care on store ack but is still updated from i_mem_rdata.
- Byte enables from latched sop and addr[1:0]:
  - SB: be=1<<a, wdata<<8a.
  - SH: be=0011<<a, wdata<<8a, misaligned if a[0]=1.
  - SW: be=1111, misaligned if a!=0.
- Misaligned store: o_mem_en is still pulsed with o_mem_we=1, be=0000 (no write), o_misalign=1 on ack.
- Misaligned load: the read proceeds normally and o_misalign=1 on ack. Load sign/zero extension (t_ldop) stays in the core.
- o_mem_* return to 0 outside ISSUE.
- o_ack is never set outside ACK. At most one o_ack bit is set at a time.
- The core sees o_ack[k] and advances. i_req[k] in the following IDLE cycle is treated as a new request.
- A single requester with continuous requests is served every MEM_LAT+3 cycles. rr_ptr still advances to its successor after each grant.

Decomposition:
- multicore_pkg: add t_arb_state enum (IDLE, ISSUE, WAIT, ACK) and a NUM_CORES default constant; reuse the existing t_sop.
- One sub-module, rr_picker: combinational. Inputs are the request vector and pointer; outputs are a valid flag and the winner index, via a rotate-then-priority-encode.

Test Plan:
- Single load: core1 req, addr 0x104, MEM_LAT=1, mem returns 0xDEADBEEF -> o_mem_en at cycle 1 with addr 0x104, be 1111. o_ack=0010 at cycle 3, o_rdata=0xDEADBEEF, o_stall[1]=1 during cycles 0-2.
- All four cores request continuously from reset -> grant order 0,1,2,3,0 with acks every 4 cycles. No core is acked twice before all others are acked once.
- SB from core2, addr 0x203, wdata 0x000000A5 -> o_mem_addr 0x200, be 1000, o_mem_wdata 0xA5000000, o_misalign 0.
- SW from core0 at addr 0x102 -> be 0000, o_mem_we 1, ack with o_misalign 1. SH at 0x101 behaves the same way.
- MEM_LAT=3: load -> ack 5 cycles after request. o_rdata equals i_mem_rdata driven 3 cycles after o_mem_en.
- i_rst asserted during WAIT -> next cycle state IDLE, no ack ever issued for that request, rr_ptr=0, all outputs 0. A held request re-arbitrates normally after reset deasserts.
